// File: rtl/program_sequencer.sv
// Instruction sequencer: holds a small loadable program store and presents one
// word at a time to the 4-bit core until a HALT word or the last address.
module program_sequencer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic [3:0]  NOP_OPCODE  = 4'h0,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  localparam int unsigned PCW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           prog_we,
  input  logic [3:0]     prog_addr,
  input  logic [3:0]     prog_data,
  output logic [3:0]     instr_out,
  output logic           instr_valid,
  output logic           busy,
  output logic           done,
  output logic [PCW-1:0] pc,
  output logic [7:0]     issue_count
);

  localparam int unsigned HW        = $clog2(HOLD_CYCLES) + 1;
  localparam logic [PCW-1:0] LAST_PC   = PCW'(DEPTH - 1);
  localparam logic [HW-1:0]  HOLD_INIT = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [3:0]     instr_q, instr_d;
  logic           valid_q, valid_d;
  logic [3:0]     rdata_q, rdata_d;

  logic [3:0]     mem_q [DEPTH];
  logic [PCW-1:0] waddr;
  logic           wr_en;

  // Writes are only accepted while idle; out-of-range addresses are dropped.
  assign waddr = PCW'(prog_addr);
  assign wr_en = (state_q == S_IDLE) && prog_we && ({28'b0, prog_addr} < DEPTH);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[waddr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      instr_q <= NOP_OPCODE;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    instr_d = instr_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        rdata_d = mem_q[pc_q];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (rdata_q == HALT_OPCODE) begin
          state_d = S_DONE;
        end else begin
          instr_d = rdata_q;
          valid_d = 1'b1;
          hold_d  = HOLD_INIT;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else begin
          valid_d = 1'b0;
          instr_d = NOP_OPCODE;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (pc_q == LAST_PC) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign done        = (state_q == S_DONE);
  assign pc          = pc_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: two instances (hold 1 and hold 3) share inputs
// and are compared cycle by cycle against a per-word trace model.
module tb_program_sequencer;

  typedef logic [15:0][3:0] prog_t;

  typedef struct packed {
    logic [3:0] instr;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] pc;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    prog_t prog;
    int    exp_cnt;
    int    exp_pc;
    int    done_h1;
    int    done_h3;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [3:0] prog_data = '0;

  logic [3:0] a_instr, b_instr;
  logic       a_valid, b_valid, a_busy, b_busy, a_done, b_done;
  logic [3:0] a_pc, b_pc;
  logic [7:0] a_cnt, b_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  obs_t exp_a [2][128];
  int   exp_done [2];

  always #5 clk = ~clk;

  program_sequencer #(.DEPTH(16), .HOLD_CYCLES(1), .NOP_OPCODE(4'h0), .HALT_OPCODE(4'hF)) u_h1 (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .instr_out(a_instr), .instr_valid(a_valid), .busy(a_busy), .done(a_done),
    .pc(a_pc), .issue_count(a_cnt)
  );

  program_sequencer #(.DEPTH(16), .HOLD_CYCLES(3), .NOP_OPCODE(4'h0), .HALT_OPCODE(4'hF)) u_h3 (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .instr_out(b_instr), .instr_valid(b_valid), .busy(b_busy), .done(b_done),
    .pc(b_pc), .issue_count(b_cnt)
  );

  function automatic obs_t mk(input int instr, input int valid, input int busy,
                              input int done, input int pc, input int cnt);
    obs_t o;
    o.instr = 4'(instr);
    o.valid = 1'(valid);
    o.busy  = 1'(busy);
    o.done  = 1'(done);
    o.pc    = 4'(pc);
    o.cnt   = 8'(cnt);
    return o;
  endfunction

  function automatic obs_t obs_of(input int k);
    if (k == 0) return {a_instr, a_valid, a_busy, a_done, a_pc, a_cnt};
    return {b_instr, b_valid, b_busy, b_done, b_pc, b_cnt};
  endfunction

  // Expected per-cycle outputs after each edge, starting with the start edge.
  function automatic void build(input int k, input prog_t p, input int hold);
    int n, a, cnt;
    bit fin;
    n = 0; a = 0; cnt = 0; fin = 1'b0;
    while (!fin) begin
      repeat (2) begin exp_a[k][n] = mk(0, 0, 1, 0, a, cnt); n++; end
      if (p[a] == 4'hF) begin
        exp_done[k] = n;
        exp_a[k][n] = mk(0, 0, 0, 1, a, cnt); n++;
        fin = 1'b1;
      end else begin
        repeat (hold) begin exp_a[k][n] = mk(int'(p[a]), 1, 1, 0, a, cnt); n++; end
        cnt++;
        if (a == 15) begin
          exp_done[k] = n;
          exp_a[k][n] = mk(0, 0, 0, 1, a, cnt); n++;
          fin = 1'b1;
        end else begin
          a++;
        end
      end
    end
    while (n < 128) begin exp_a[k][n] = mk(0, 0, 0, 0, a, cnt); n++; end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic load(input prog_t p);
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = p[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic run(input string tag, input prog_t p, input bit noise,
                     output int d1, output int d3);
    int len, lim;
    int dn [2];
    obs_t o;
    build(0, p, 1);
    build(1, p, 3);
    len = ((exp_done[0] > exp_done[1]) ? exp_done[0] : exp_done[1]) + 3;
    lim = (exp_done[0] < exp_done[1]) ? exp_done[0] : exp_done[1];
    dn[0] = -1; dn[1] = -1;
    start = 1'b1;
    tick();
    start = 1'b0; prog_we = 1'b0;
    for (int c = 0; c < len; c++) begin
      if (c > 0) tick();
      for (int k = 0; k < 2; k++) begin
        o = obs_of(k);
        chk($sformatf("%s h%0d cyc%0d", tag, (k == 0) ? 1 : 3, c), 32'(o), 32'(exp_a[k][c]));
        if (o.done && dn[k] < 0) dn[k] = c;
      end
      if (noise && c <= lim) begin
        start     = 1'($urandom_range(0, 1));
        prog_we   = 1'($urandom_range(0, 1));
        prog_addr = 4'($urandom);
        prog_data = 4'($urandom);
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
    end
    start = 1'b0; prog_we = 1'b0;
    d1 = dn[0]; d3 = dn[1];
  endtask

  initial begin
    vec_t  tab [5];
    prog_t p;
    int    d1, d3;
    obs_t  rst_obs;

    tab[0] = '{prog: 64'h0000_0000_0000_0F53, exp_cnt: 2,  exp_pc: 2,  done_h1: 8,  done_h3: 12};
    tab[1] = '{prog: 64'h0000_0000_0000_000F, exp_cnt: 0,  exp_pc: 0,  done_h1: 2,  done_h3: 2};
    tab[2] = '{prog: 64'h0EDC_BA98_7654_3210, exp_cnt: 16, exp_pc: 15, done_h1: 48, done_h3: 80};
    tab[3] = '{prog: 64'h0000_0000_00FE_8421, exp_cnt: 5,  exp_pc: 5,  done_h1: 17, done_h3: 27};
    tab[4] = '{prog: 64'hF111_1111_1111_1111, exp_cnt: 15, exp_pc: 15, done_h1: 47, done_h3: 77};
    rst_obs = mk(0, 0, 0, 0, 0, 0);

    rst = 1'b1;
    tick(); tick();
    chk("reset h1", 32'(obs_of(0)), 32'(rst_obs));
    chk("reset h3", 32'(obs_of(1)), 32'(rst_obs));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      load(tab[i].prog);
      run($sformatf("vec%0d", i), tab[i].prog, 1'b0, d1, d3);
      chk($sformatf("vec%0d done_at h1", i), 32'(d1), 32'(tab[i].done_h1));
      chk($sformatf("vec%0d done_at h3", i), 32'(d3), 32'(tab[i].done_h3));
      chk($sformatf("vec%0d count h1", i), 32'(a_cnt), 32'(tab[i].exp_cnt));
      chk($sformatf("vec%0d count h3", i), 32'(b_cnt), 32'(tab[i].exp_cnt));
      chk($sformatf("vec%0d pc h1", i), 32'(a_pc), 32'(tab[i].exp_pc));
      chk($sformatf("vec%0d pc h3", i), 32'(b_pc), 32'(tab[i].exp_pc));
      tick();
    end

    // Writes and starts during a run must leave the store and the run intact.
    load(tab[0].prog);
    run("noisy", tab[0].prog, 1'b1, d1, d3);
    tick();
    run("rerun", tab[0].prog, 1'b0, d1, d3);
    tick();

    // Reset in the middle of EXEC aborts without a done pulse.
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("pre-rst valid h1", 32'(a_valid), 32'd1);
    chk("pre-rst valid h3", 32'(b_valid), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("abort h1 cyc%0d", c), 32'(obs_of(0)), 32'(rst_obs));
      chk($sformatf("abort h3 cyc%0d", c), 32'(obs_of(1)), 32'(rst_obs));
      tick();
    end

    // Write to address 0 in the same cycle as start: the new word is issued.
    p = tab[0].prog;
    p[0] = 4'h7;
    prog_we = 1'b1; prog_addr = 4'h0; prog_data = 4'h7;
    run("wr+start", p, 1'b0, d1, d3);
    chk("wr+start done h1", 32'(d1), 32'd8);
    tick();

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++) begin
        p[i] = 4'($urandom_range(0, 15));
        if (r % 2 == 0 && p[i] == 4'hF) p[i] = 4'h0;
      end
      load(p);
      run($sformatf("rand%0d", r), p, 1'b1, d1, d3);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
